// File: rtl/gemm_tile_sched.sv
// Tile scheduler for the gemm datapath: walks N-tiles, K-tiles and M-rows,
// emits one operand row per available source row and tags it with accumulation flags.
module gemm_tile_sched #(
    parameter int SZI             = 64,
    parameter int MAX_TILE_SIZE_M = 512,
    parameter int CNT_W           = 16,
    parameter int PIPE_LAT        = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] tile_size_m,
    input  logic [CNT_W-1:0] num_tiles_k,
    input  logic [CNT_W-1:0] num_tiles_n,
    input  logic             src_valid,
    output logic             src_rdreq,
    output logic             info_valid,
    output logic             first_tile_k,
    output logic             last_tile_k,
    output logic             new_tile_k,
    output logic [CNT_W-1:0] row_idx,
    output logic [CNT_W-1:0] tile_k_idx,
    output logic [CNT_W-1:0] tile_n_idx,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Loaded one short so DONE lands exactly 2*SZI+PIPE_LAT cycles after the last emit.
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(2*SZI + PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] MAX_M      = CNT_W'(MAX_TILE_SIZE_M);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
    logic [CNT_W-1:0] tsm_q, tsm_d, ntk_q, ntk_d, ntn_q, ntn_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic             cfg_err_q, cfg_err_d;

    logic emit, m_last, k_last, n_last, bad_cfg;

    assign emit    = (state_q == S_RUN) && src_valid;
    assign m_last  = (m_q == tsm_q - ONE);
    assign k_last  = (k_q == ntk_q - ONE);
    assign n_last  = (n_q == ntn_q - ONE);
    assign bad_cfg = (tile_size_m == '0) || (tile_size_m > MAX_M) ||
                     (num_tiles_k == '0) || (num_tiles_n == '0);

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        k_d       = k_q;
        n_d       = n_q;
        tsm_d     = tsm_q;
        ntk_d     = ntk_q;
        ntn_d     = ntn_q;
        drain_d   = drain_q;
        cfg_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tsm_d = tile_size_m;
                    ntk_d = num_tiles_k;
                    ntn_d = num_tiles_n;
                    if (bad_cfg) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        m_d     = '0;
                        k_d     = '0;
                        n_d     = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (emit) begin
                    if (!m_last) begin
                        m_d = m_q + ONE;
                    end else begin
                        m_d = '0;
                        if (!k_last) begin
                            k_d = k_q + ONE;
                        end else begin
                            k_d = '0;
                            if (!n_last) begin
                                n_d = n_q + ONE;
                            end else begin
                                n_d     = '0;
                                drain_d = DRAIN_LOAD;
                                state_d = S_DRAIN;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q <= ONE) state_d = S_DONE;
                else                drain_d = drain_q - ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            tsm_q     <= '0;
            ntk_q     <= '0;
            ntn_q     <= '0;
            drain_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            k_q       <= k_d;
            n_q       <= n_d;
            tsm_q     <= tsm_d;
            ntk_q     <= ntk_d;
            ntn_q     <= ntn_d;
            drain_q   <= drain_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Flags are gated by emit so a stalled cycle never looks like a valid row.
    assign src_rdreq    = emit;
    assign info_valid   = emit;
    assign first_tile_k = emit && (k_q == '0);
    assign last_tile_k  = emit && k_last;
    assign new_tile_k   = emit && (m_q == '0);
    assign row_idx      = m_q;
    assign tile_k_idx   = k_q;
    assign tile_n_idx   = n_q;
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_gemm_tile_sched.sv
// Directed/random bench for gemm_tile_sched against a nested-loop row model.
module tb_gemm_tile_sched;
    localparam int CW    = 16;
    localparam int DRAIN = 2*64 + 8;

    logic          clk = 1'b0, resetn = 1'b1, start = 1'b0, src_valid = 1'b0;
    logic [CW-1:0] tile_size_m = '0, num_tiles_k = '0, num_tiles_n = '0;
    logic          src_rdreq, info_valid, first_tile_k, last_tile_k, new_tile_k;
    logic [CW-1:0] row_idx, tile_k_idx, tile_n_idx;
    logic          busy, done, cfg_err;

    gemm_tile_sched dut (
        .clk(clk), .resetn(resetn), .start(start),
        .tile_size_m(tile_size_m), .num_tiles_k(num_tiles_k), .num_tiles_n(num_tiles_n),
        .src_valid(src_valid), .src_rdreq(src_rdreq), .info_valid(info_valid),
        .first_tile_k(first_tile_k), .last_tile_k(last_tile_k), .new_tile_k(new_tile_k),
        .row_idx(row_idx), .tile_k_idx(tile_k_idx), .tile_n_idx(tile_n_idx),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit f; bit l; bit nw; int m; int k; int n; } row_t;
    row_t expq[$];
    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ctl"}, {24'h0, src_rdreq, info_valid, first_tile_k, last_tile_k,
                            new_tile_k, busy, done, cfg_err}, 32'h0);
        chk({tag, "_idx"}, {row_idx, tile_k_idx} | {16'h0, tile_n_idx}, 32'h0);
    endtask

    task automatic build(input int tsm, input int ntk, input int ntn);
        row_t r;
        expq.delete();
        for (int n = 0; n < ntn; n++)
            for (int k = 0; k < ntk; k++)
                for (int m = 0; m < tsm; m++) begin
                    r.f = (k == 0); r.l = (k == ntk - 1); r.nw = (m == 0);
                    r.m = m; r.k = k; r.n = n;
                    expq.push_back(r);
                end
    endtask

    task automatic do_start(input int tsm, input int ntk, input int ntn);
        @(negedge clk);
        tile_size_m = CW'(tsm); num_tiles_k = CW'(ntk); num_tiles_n = CW'(ntn);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one layer; returns early (aborted=1) if reset is injected at reset_row.
    task automatic run_layer(input int tsm, input int ntk, input int ntn, input int pct,
                             input int mid_row, input int reset_row, output bit aborted);
        int   emitted = 0, cyc = 0, dcnt = 1;
        bit   seen = 0, e;
        row_t r;
        aborted = 0;
        build(tsm, ntk, ntn);
        do_start(tsm, ntk, ntn);
        #1 chk("busy_after_start", busy, 1);
        while (expq.size() > 0 && cyc < 3000) begin
            src_valid = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            if (emitted == reset_row) begin
                resetn = 1'b0;
                #1 all_zero("reset_mid_run");
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk); #1;
                    chk("no_done_after_reset", done, 0);
                    chk("no_busy_after_reset", busy, 0);
                end
                src_valid = 1'b0;
                resetn = 1'b1;
                aborted = 1;
                return;
            end
            if (emitted == mid_row) begin
                start = 1'b1; tile_size_m = 7; num_tiles_k = 5; num_tiles_n = 5;
            end
            #1;
            e = src_valid;
            chk("src_rdreq", src_rdreq, e);
            chk("info_valid", info_valid, e);
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            if (e) begin
                r = expq.pop_front();
                chk("first_tile_k", first_tile_k, r.f);
                chk("last_tile_k", last_tile_k, r.l);
                chk("new_tile_k", new_tile_k, r.nw);
                chk("row_idx", row_idx, r.m);
                chk("tile_k_idx", tile_k_idx, r.k);
                chk("tile_n_idx", tile_n_idx, r.n);
                emitted++;
            end else begin
                chk("flags_idle", {first_tile_k, last_tile_k, new_tile_k}, 0);
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("rows_left", expq.size(), 0);
        while (!seen && dcnt < 400) begin
            src_valid = $urandom_range(1);
            #1;
            if (done) begin
                chk("drain_len", dcnt, DRAIN);
                chk("busy_at_done", busy, 0);
                seen = 1;
            end else begin
                chk("busy_drain", busy, 1);
                chk("rdreq_drain", src_rdreq, 0);
            end
            @(negedge clk);
            dcnt++;
        end
        chk("done_seen", seen, 1);
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        src_valid = 1'b0;
    endtask

    initial begin
        bit ab;
        #2 resetn = 1'b0;
        #1 all_zero("reset");
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;

        run_layer(4, 3, 2, 100, -1, -1, ab);   // back-to-back rows
        run_layer(4, 3, 2, 30, -1, -1, ab);    // throttled source
        run_layer(2, 1, 3, 100, -1, -1, ab);   // single K-tile
        run_layer(3, 2, 2, 60, 5, -1, ab);     // start while busy is ignored

        // Rejected configurations
        do_start(513, 3, 2);
        src_valid = 1'b1;
        #1;
        chk("cfg_err_tsm", cfg_err, 1);
        chk("cfg_err_tsm_busy", busy, 0);
        chk("cfg_err_tsm_rdreq", src_rdreq, 0);
        @(negedge clk); #1;
        chk("cfg_err_pulse", cfg_err, 0);
        chk("cfg_err_idle", busy, 0);
        do_start(4, 3, 0);
        #1;
        chk("cfg_err_ntn", cfg_err, 1);
        chk("cfg_err_ntn_busy", busy, 0);
        chk("cfg_err_ntn_rdreq", src_rdreq, 0);
        src_valid = 1'b0;
        @(negedge clk); #1;
        chk("cfg_err_ntn_pulse", cfg_err, 0);

        run_layer(4, 3, 2, 100, -1, 7, ab);    // reset at row 7
        chk("reset_aborted", ab, 1);
        run_layer(4, 3, 2, 100, -1, -1, ab);   // fresh full run after reset

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/gemm_tile_sched.md
Name: gemm_tile_sched

Overview:
Sequences operand rows into the gemm datapath and generates the per-row Info flags (valid, first_tile_k, last_tile_k, new_tile_k) that the accumulation memory uses to initialise, accumulate and retire partial sums.
- Walks a layer as N-tiles (outer loop), K-tiles (middle loop) and M-rows (inner loop).
- Throttles on upstream operand availability.
- Holds busy until the systolic and accumulation pipeline has drained, then pulses done.
- Sits between the layer-parameter/instruction decoder and the gemm a/b operand feeders.

Parameters:
SZI, 64, systolic array dimension; sets drain depth.
MAX_TILE_SIZE_M, 512, accumulator FIFO depth; upper bound on tile_size_m.
CNT_W, 16, width of all tile/row counters and count inputs.
PIPE_LAT, 8, fixed latency of mxu plus accum_mem beyond the 2*SZI skew.

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; latches the count inputs and begins a layer
tile_size_m  input  CNT_W  rows per tile, valid range 1..MAX_TILE_SIZE_M
num_tiles_k  input  CNT_W  K-tiles per output tile, at least 1
num_tiles_n  input  CNT_W  output tiles per layer, at least 1
src_valid  input  1  upstream a/b operand row available this cycle
src_rdreq  output  1  consume one operand row this cycle
info_valid  output  1  Info.valid for the emitted row
first_tile_k  output  1  row belongs to K-tile 0
last_tile_k  output  1  row belongs to K-tile num_tiles_k-1
new_tile_k  output  1  first row of a K-tile
row_idx  output  CNT_W  M index of the emitted row
tile_k_idx  output  CNT_W  current K-tile index
tile_n_idx  output  CNT_W  current N-tile index
busy  output  1  layer in progress, including drain
done  output  1  one-cycle pulse when the drain completes
cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
Reset:
- Every output is 0.
- FSM returns to IDLE and counters clear.
- Reset mid-run aborts immediately with no done pulse.

FSM states: IDLE, RUN, DRAIN, DONE.

IDLE:
- On start, check the latched counts. If tile_size_m==0, tile_size_m>MAX_TILE_SIZE_M, num_tiles_k==0 or num_tiles_n==0: pulse cfg_err the next cycle and stay in IDLE.
- Otherwise clear counters, go to RUN and assert busy from the next cycle.

RUN (emit):
- A row is emitted in a cycle iff src_valid is high.
- On emit: src_rdreq=info_valid=1, both combinational from src_valid and the state. The flags and indices are driven from the current counters in the same cycle.
- On a non-emit cycle: src_rdreq=info_valid=0 and all flags are 0; indices hold.

Flags for an emitted row:
- first_tile_k = (k==0).
- last_tile_k = (k==num_tiles_k-1). When num_tiles_k==1, both first_tile_k and last_tile_k are set.
- new_tile_k = (m==0).

Counter advance, on emit only:
- m increments. At tile_size_m-1, m wraps to 0 and k increments.
- At num_tiles_k-1, k wraps to 0 and n increments.
- Emitting the final row (m, k, n all at max) goes to DRAIN.
- No bubble is inserted at tile boundaries; back-to-back rows are allowed across K and N boundaries.

DRAIN:
- Load a down-counter with 2*SZI+PIPE_LAT.
- No emits; src_rdreq=0 regardless of src_valid.
- When the counter reaches 0, go to DONE.

DONE:
- done=1 for exactly one cycle; busy drops in the same cycle.
- Go to IDLE.

start while busy is ignored; the latched counts do not change.

FIFO safety:
- Rows per K-tile never exceed MAX_TILE_SIZE_M, so the accumulator FIFO cannot overflow.
- Scheduler flags never request a FIFO write on a last_tile_k row.

Widths and counts:
- Counters are unsigned CNT_W; comparisons use the latched counts.
- Total emitted rows = tile_size_m*num_tiles_k*num_tiles_n.

Test Plan:
- tile_size_m=4, num_tiles_k=3, num_tiles_n=2, src_valid held high -> 24 consecutive emits.
  - first_tile_k on rows 0-3 and 12-15; last_tile_k on rows 8-11 and 20-23; new_tile_k on every 4th row.
  - busy low 2*SZI+PIPE_LAT cycles after the last emit (136 with defaults), with done pulsing once in that cycle.
- Same configuration, src_valid random at 30% -> identical flag/index sequence over emitting cycles only; src_rdreq==info_valid every cycle; no emit while src_valid=0.
- num_tiles_k=1, tile_size_m=2, num_tiles_n=3 -> every row has first_tile_k=last_tile_k=1; new_tile_k on rows 0, 2, 4.
- start with tile_size_m=513, then with num_tiles_n=0 -> cfg_err pulse each time; busy stays 0; no src_rdreq.
- Second start asserted mid-RUN -> ignored; the row count stays that of the first configuration.
- resetn asserted at row 7 of the first scenario -> all outputs 0 asynchronously; no done; a fresh start after release runs the full 24 rows.
